serial_pattern_detector: RTL
============================

// Module: serial_pattern_detector
// PURPOSE
//   Downstream consumer of the gated D-latch storage stage.
//   - Samples the latch's q output as a serial bit stream on each rising edge of c.
//   - Holds the last N accepted bits in a shift window.
//   - Pulses match when the window equals PATTERN; overlapping occurrences are detected.
//   - Keeps a saturating count of matches.
// PARAMETERS
//   N        4        window / pattern length in bits, N >= 2
//   PATTERN  4'b1011  N-bit pattern; MSB is the oldest bit, LSB the newest
//   CW       8        match counter width in bits, CW >= 1
// PORTS
//   c      in   1   clock, rising-edge active
//   rst    in   1   synchronous reset, active-high
//   en     in   1   sample enable; d accepted only on edges where en=1
//   d      in   1   serial data bit (latch q)
//   clr    in   1   synchronous clear of count/full only
//   sr     out  N   shift window; sr[0] = newest accepted bit
//   armed  out  1   1 once N bits accepted since reset
//   match  out  1   registered one-cycle match pulse
//   count  out  CW  number of matches, saturating
//   full   out  1   1 while count == 2^CW-1
// BEHAVIOUR
//   Clocking and reset
//   - One clock; all state updates on rising c. There are no asynchronous paths.
//   - Reset is synchronous and active-high. rst=1 at an edge overrides en and clr.
//   - Reset values: sr=0, armed=0, match=0, count=0, full=0, fill counter=0, state=FILL.
//   State machine
//   - FILL:  fewer than N bits accepted; armed=0.
//   - ARMED: N or more bits accepted; armed=1.
//   - FILL->ARMED on the edge that accepts the Nth bit.
//   - ARMED is left only via rst.
//   - The internal fill counter saturates at N.
//   Accept edge (en=1, rst=0)
//   - sr <= {sr[N-2:0], d}.
//   - match <= ({sr[N-2:0],d} == PATTERN) && (fill >= N-1).
//   - Latency: match is high in the cycle right after the edge that sampled the completing bit.
//   - The window reset value never produces a match; this holds even for PATTERN=0.
//   Hold edge (en=0)
//   - sr, fill and state hold.
//   - match <= 0.
//   Counter
//   - count increments on the same edge that sets match=1.
//   - Saturates at 2^CW-1 with no wrap; full=1 exactly while count == 2^CW-1.
//   - clr=1: count <= 0 and full <= 0. clr beats a simultaneous match increment.
//   - clr does not suppress match, and does not touch sr or state.
//   Overlap
//   - The window slides by one bit per accept, so back-to-back matches are possible.
//   - Example: a 1111 pattern on a constant 1 stream matches on every accept after arming.
// TESTING
//   T1 rst; en=1; d=1,0,1,1 on 4 edges
//      -> after 4th edge: match=1 for 1 cycle, count=1, armed=1, sr=4'b1011.
//   T2 d=1,0,1,1,0,1,1
//      -> match after edges 4 and 7 only, count=2 (overlap reuses bit 4).
//   T3 d=1,0,1; en=0 for 3 edges; then en=1, d=1
//      -> no match during the gap (sr=4'b0101 held); match after the final edge.
//   T4 d=1,0,1; rst; then d=1
//      -> armed=0, match=0, sr=4'b0001, count=0.
//   T5 CW=2: 4 matches
//      -> count=3, full=1 after the 3rd and stays 3.
//      -> clr on the edge of the 5th match: count=0, full=0, match=1.
//   T6 PATTERN=4'b0000; rst; d=0 x3
//      -> no match; 4th 0 -> match=1; further 0s -> match every edge.

Source files
------------

// File: rtl/serial_pattern_detector_if.sv
// Serial detector bus: sample enable/data/clear in, window and match status out.
interface serial_pattern_detector_if #(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
);

  logic          en;
  logic          d;
  logic          clr;
  logic [N-1:0]  sr;
  logic          armed;
  logic          match;
  logic [CW-1:0] count;
  logic          full;

  // Producer side: drives the bit stream and observes detector status.
  modport master (
    output en, d, clr,
    input  sr, armed, match, count, full
  );

  // Detector side.
  modport slave (
    input  en, d, clr,
    output sr, armed, match, count, full
  );

endinterface

// File: rtl/serial_pattern_detector.sv
// Serial pattern detector: shifts accepted bits into an N-bit window, pulses
// match on every (overlapping) occurrence of PATTERN and keeps a saturating
// match count. Synchronous active-high reset.
module serial_pattern_detector #(
  parameter int unsigned    N       = 4,
  parameter logic [N-1:0]   PATTERN = N'(4'b1011),
  parameter int unsigned    CW      = 8
) (
  input  logic                   c,
  input  logic                   rst,
  serial_pattern_detector_if.slave bus
);

  localparam int unsigned   FW        = $clog2(N + 1);
  localparam logic [FW-1:0] FILL_LAST = FW'(N - 1);
  localparam logic [FW-1:0] FILL_MAX  = FW'(N);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

  typedef enum logic {
    FILL  = 1'b0,
    ARMED = 1'b1
  } state_t;

  state_t        state_q,  state_nxt;
  logic [N-1:0]  sr_q,     sr_nxt;
  logic [FW-1:0] fill_q,   fill_nxt;
  logic          armed_q,  armed_nxt;
  logic          match_q,  match_nxt;
  logic [CW-1:0] count_q,  count_nxt;
  logic          full_q,   full_nxt;
  logic [N-1:0]  window_c;

  // Next-state, window, match and counter logic.
  always_comb begin
    state_nxt = state_q;
    sr_nxt    = sr_q;
    fill_nxt  = fill_q;
    match_nxt = 1'b0;
    count_nxt = count_q;
    window_c  = {sr_q[N-2:0], bus.d};

    // The fill qualifier keeps the reset window from matching, even for an all-zero pattern.
    if (bus.en) begin
      sr_nxt    = window_c;
      match_nxt = (window_c == PATTERN) && (fill_q >= FILL_LAST);
      if (fill_q != FILL_MAX) begin
        fill_nxt = fill_q + FW'(1);
      end
    end

    case (state_q)
      FILL: begin
        if (bus.en && (fill_q == FILL_LAST)) begin
          state_nxt = ARMED;
        end
      end
      ARMED:   state_nxt = ARMED;
      default: state_nxt = FILL;
    endcase

    // Clear wins over a coincident increment; saturate instead of wrapping.
    if (bus.clr) begin
      count_nxt = '0;
    end else if (match_nxt && (count_q != CNT_MAX)) begin
      count_nxt = count_q + CW'(1);
    end

    full_nxt  = (count_nxt == CNT_MAX);
    armed_nxt = (state_nxt == ARMED);
  end

  // State and output registers.
  always_ff @(posedge c) begin
    if (rst) begin
      state_q <= FILL;
      sr_q    <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      match_q <= 1'b0;
      count_q <= '0;
      full_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      sr_q    <= sr_nxt;
      fill_q  <= fill_nxt;
      armed_q <= armed_nxt;
      match_q <= match_nxt;
      count_q <= count_nxt;
      full_q  <= full_nxt;
    end
  end

  assign bus.sr    = sr_q;
  assign bus.armed = armed_q;
  assign bus.match = match_q;
  assign bus.count = count_q;
  assign bus.full  = full_q;

endmodule
